// File: rtl/bp_be_mmio_clint.sv
// bp_be_mmio_clint: core-local interruptor on the BE MMIO map.
// Holds the free-running mtime, per-hart mtimecmp and msip, and serves one
// outstanding dword load/store at a time through an IDLE/RESP handshake.
// Build option: define BP_BE_CLINT_MTIME_DIV_EN to advance mtime once every
// mtime_div_p clocks instead of every clock.
module bp_be_mmio_clint #(
    parameter int num_core_p    = 1,
    parameter int vaddr_width_p = 39,
    parameter int dword_width_p = 64,
    parameter int mtime_div_p   = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     mmio_v_i,
    input  logic                     mmio_w_i,
    input  logic [vaddr_width_p-1:0] mmio_addr_i,
    input  logic [dword_width_p-1:0] mmio_data_i,
    output logic                     mmio_ready_o,
    output logic                     resp_v_o,
    output logic [dword_width_p-1:0] resp_data_o,
    output logic                     resp_err_o,
    input  logic                     resp_yumi_i,
    output logic [num_core_p-1:0]    timer_irq_o,
    output logic [num_core_p-1:0]    soft_irq_o
);

    localparam logic [vaddr_width_p-1:0] mtime_addr_lp    = vaddr_width_p'(39'h6f_ffff_0000);
    localparam logic [vaddr_width_p-1:0] mtimecmp_base_lp = vaddr_width_p'(39'h6f_ffff_0100);
    localparam logic [vaddr_width_p-1:0] msip_base_lp     = vaddr_width_p'(39'h6f_ffff_0200);

    typedef enum logic {IDLE, RESP} state_e;

    state_e                   state_q, state_d;
    logic                     resp_v_q, resp_v_d;
    logic [dword_width_p-1:0] resp_data_q, resp_data_d;
    logic                     resp_err_q, resp_err_d;
    logic [dword_width_p-1:0] mtime_q, mtime_d;
    logic [dword_width_p-1:0] mtimecmp_q [num_core_p];
    logic [dword_width_p-1:0] mtimecmp_d [num_core_p];
    logic [num_core_p-1:0]    msip_q, msip_d;
    logic [num_core_p-1:0]    timer_irq_q, timer_irq_d;

    logic                     is_mtime;
    logic [num_core_p-1:0]    cmp_hit;
    logic [num_core_p-1:0]    msip_hit;
    logic                     mapped;
    logic [dword_width_p-1:0] rdata;
    logic                     accept;
    logic                     wr;
    logic                     mtime_tick;

    if (mtime_div_p < 1) begin : g_div_chk
        $error("mtime_div_p must be positive");
    end

    // Full-address decode of the request and selection of load data.
    always_comb begin
        is_mtime = (mmio_addr_i == mtime_addr_lp);
        cmp_hit  = '0;
        msip_hit = '0;
        rdata    = is_mtime ? mtime_q : '0;
        for (int i = 0; i < num_core_p; i++) begin
            cmp_hit[i]  = (mmio_addr_i == mtimecmp_base_lp + vaddr_width_p'(8 * i));
            msip_hit[i] = (mmio_addr_i == msip_base_lp + vaddr_width_p'(8 * i));
            if (cmp_hit[i])  rdata = mtimecmp_q[i];
            if (msip_hit[i]) rdata = dword_width_p'(msip_q[i]);
        end
        mapped = is_mtime | (|cmp_hit) | (|msip_hit);
        accept = (state_q == IDLE) & mmio_v_i;
        wr     = accept & mmio_w_i;
    end

`ifdef BP_BE_CLINT_MTIME_DIV_EN
    if (mtime_div_p < 2) begin : g_div_min_chk
        $error("mtime_div_p must be at least 2");
    end

    localparam int div_w_lp = $clog2(mtime_div_p);
    localparam logic [div_w_lp-1:0] div_max_lp = div_w_lp'(mtime_div_p - 1);

    logic [div_w_lp-1:0] div_cnt_q, div_cnt_d;

    // Prescaler: mtime advances on the cycle the counter wraps; an mtime store restarts it.
    always_comb begin
        mtime_tick = (div_cnt_q == div_max_lp);
        if ((wr & is_mtime) | mtime_tick) div_cnt_d = '0;
        else                              div_cnt_d = div_cnt_q + 1'b1;
    end

    // Prescaler counter register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) div_cnt_q <= '0;
        else         div_cnt_q <= div_cnt_d;
    end
`else
    assign mtime_tick = 1'b1;
`endif

    // Next-state for timer registers, interrupt lines and the request FSM.
    always_comb begin
        if (wr & is_mtime)  mtime_d = mmio_data_i;
        else if (mtime_tick) mtime_d = mtime_q + 1'b1;
        else                 mtime_d = mtime_q;

        msip_d = msip_q;
        for (int i = 0; i < num_core_p; i++) begin
            mtimecmp_d[i] = (wr & cmp_hit[i]) ? mmio_data_i : mtimecmp_q[i];
            if (wr & msip_hit[i]) msip_d[i] = mmio_data_i[0];
            // Compare against post-edge values so a store takes effect next cycle.
            timer_irq_d[i] = (mtime_d >= mtimecmp_d[i]);
        end

        state_d     = state_q;
        resp_v_d    = resp_v_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            IDLE: begin
                if (mmio_v_i) begin
                    state_d     = RESP;
                    resp_v_d    = 1'b1;
                    resp_data_d = mmio_w_i ? '0 : rdata;
                    resp_err_d  = ~mapped;
                end
            end
            RESP: begin
                if (resp_yumi_i) begin
                    state_d  = IDLE;
                    resp_v_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single register stage for FSM, response and timer state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            resp_v_q    <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            mtime_q     <= '0;
            msip_q      <= '0;
            timer_irq_q <= '0;
            for (int i = 0; i < num_core_p; i++) mtimecmp_q[i] <= '1;
        end else begin
            state_q     <= state_d;
            resp_v_q    <= resp_v_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            mtime_q     <= mtime_d;
            msip_q      <= msip_d;
            timer_irq_q <= timer_irq_d;
            for (int i = 0; i < num_core_p; i++) mtimecmp_q[i] <= mtimecmp_d[i];
        end
    end

    assign mmio_ready_o = (state_q == IDLE);
    assign resp_v_o     = resp_v_q;
    assign resp_data_o  = resp_data_q;
    assign resp_err_o   = resp_err_q;
    assign timer_irq_o  = timer_irq_q;
    assign soft_irq_o   = msip_q;

endmodule

// File: tb/tb_bp_be_mmio_clint.sv
// tb_bp_be_mmio_clint: directed and randomized requests against a reference
// model that derives mtime from elapsed clock edges since the last store.
module tb_bp_be_mmio_clint;

`ifdef BP_BE_CLINT_MTIME_DIV_EN
    localparam int DIV = 16;
`else
    localparam int DIV = 1;
`endif
    localparam logic [38:0] A_MTIME = 39'h6f_ffff_0000;
    localparam logic [38:0] A_CMP   = 39'h6f_ffff_0100;
    localparam logic [38:0] A_MSIP  = 39'h6f_ffff_0200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mmio_v = 1'b0;
    logic        mmio_w = 1'b0;
    logic [38:0] mmio_addr = '0;
    logic [63:0] mmio_data = '0;
    logic        mmio_ready;
    logic        resp_v;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        resp_yumi = 1'b0;
    logic [0:0]  timer_irq;
    logic [0:0]  soft_irq;

    bp_be_mmio_clint #(
        .num_core_p(1), .vaddr_width_p(39), .dword_width_p(64), .mtime_div_p(16)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .mmio_v_i(mmio_v), .mmio_w_i(mmio_w), .mmio_addr_i(mmio_addr), .mmio_data_i(mmio_data),
        .mmio_ready_o(mmio_ready),
        .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_err_o(resp_err), .resp_yumi_i(resp_yumi),
        .timer_irq_o(timer_irq), .soft_irq_o(soft_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Edges elapsed since reset release.
    int unsigned cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Reference model: mtime after edge n = m_base + (n - m_nb) / DIV.
    logic [63:0] m_base;
    int unsigned m_nb;
    logic [63:0] m_cmp;
    logic        m_msip;
    bit          mon_en = 1'b0;

    function automatic logic [63:0] mt_at(input int unsigned n);
        return m_base + 64'((n - m_nb) / DIV);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Interrupt lines follow the model every cycle.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("timer_irq", 64'(timer_irq), 64'(mt_at(cyc) >= m_cmp));
            chk("soft_irq", 64'(soft_irq), 64'(m_msip));
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        mmio_v = 1'b0;
        resp_yumi = 1'b0;
        m_base = '0;
        m_nb = 0;
        m_cmp = '1;
        m_msip = 1'b0;
        #1;
        chk("rst_resp_v", 64'(resp_v), 64'(0));
        chk("rst_resp_data", resp_data, 64'(0));
        chk("rst_resp_err", 64'(resp_err), 64'(0));
        chk("rst_ready", 64'(mmio_ready), 64'(1));
        chk("rst_timer_irq", 64'(timer_irq), 64'(0));
        chk("rst_soft_irq", 64'(soft_irq), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One request; hold yumi low for 'hold' cycles while offering a stray store.
    task automatic req(input logic w, input logic [38:0] a, input logic [63:0] d, input int hold);
        logic [63:0] exp_d;
        logic        exp_e;
        int unsigned k;
        @(negedge clk);
        chk("ready_idle", 64'(mmio_ready), 64'(1));
        mmio_v = 1'b1; mmio_w = w; mmio_addr = a; mmio_data = d;
        @(posedge clk);
        #1;
        k = cyc;
        mmio_v = 1'b0;
        exp_e = 1'b1;
        exp_d = '0;
        if (a == A_MTIME) begin
            exp_e = 1'b0;
            exp_d = mt_at(k - 1);
            if (w) begin m_base = d; m_nb = k; end
        end else if (a == A_CMP) begin
            exp_e = 1'b0;
            exp_d = m_cmp;
            if (w) m_cmp = d;
        end else if (a == A_MSIP) begin
            exp_e = 1'b0;
            exp_d = {63'b0, m_msip};
            if (w) m_msip = d[0];
        end
        if (w) exp_d = '0;
        @(negedge clk);
        chk("resp_v", 64'(resp_v), 64'(1));
        chk("resp_data", resp_data, exp_d);
        chk("resp_err", 64'(resp_err), 64'(exp_e));
        chk("ready_busy", 64'(mmio_ready), 64'(0));
        for (int h = 0; h < hold; h++) begin
            mmio_v = 1'b1; mmio_w = 1'b1; mmio_addr = A_MSIP; mmio_data = {63'b0, ~m_msip};
            @(negedge clk);
            chk("hold_resp_v", 64'(resp_v), 64'(1));
            chk("hold_resp_data", resp_data, exp_d);
            chk("hold_ready", 64'(mmio_ready), 64'(0));
        end
        mmio_v = 1'b0;
        resp_yumi = 1'b1;
        @(posedge clk);
        #1;
        resp_yumi = 1'b0;
        @(negedge clk);
        chk("after_yumi_v", 64'(resp_v), 64'(0));
        chk("after_yumi_ready", 64'(mmio_ready), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [38:0] unm [4];
        unm[0] = A_CMP + 39'd8;
        unm[1] = A_MTIME + 39'd4;
        unm[2] = A_MSIP + 39'd8;
        unm[3] = 39'h00_1234_5678;

        do_reset();
        mon_en = 1'b1;

        // Free-running count after reset, then stray yumi while idle.
        repeat (4) @(negedge clk);
        resp_yumi = 1'b1;
        @(negedge clk);
        resp_yumi = 1'b0;
        chk("yumi_idle_v", 64'(resp_v), 64'(0));
        req(1'b0, A_MTIME, 64'd0, 0);

        // Timer compare: mtime=10, mtimecmp=20, watch the interrupt rise, then disarm.
        req(1'b1, A_MTIME, 64'd10, 0);
        req(1'b1, A_CMP, 64'd20, 0);
        repeat (12 * DIV) @(negedge clk);
        chk("t2_irq_set", 64'(timer_irq), 64'(1));
        req(1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        @(negedge clk);
        chk("t2_irq_clr", 64'(timer_irq), 64'(0));

        // Software interrupt: only bit 0 kept.
        req(1'b1, A_MSIP, 64'h3, 0);
        req(1'b0, A_MSIP, 64'd0, 0);
        req(1'b1, A_MSIP, 64'd0, 0);

        // Unmapped addresses, including the hart index beyond num_core_p.
        req(1'b0, A_CMP + 39'd8, 64'd0, 0);
        req(1'b0, A_MTIME + 39'd4, 64'd0, 0);
        req(1'b1, A_MSIP + 39'd8, 64'd1, 0);
        req(1'b1, A_CMP + 39'd8, 64'd0, 0);

        // Wrap of mtime with a stalled response.
        req(1'b1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 4);
        repeat (2 * DIV) @(negedge clk);
        req(1'b0, A_MTIME, 64'd0, 0);

        // Randomized mix.
        for (int n = 0; n < 60; n++) begin
            int unsigned sel;
            sel = $urandom_range(0, 6);
            case (sel)
                0: req(1'b0, A_MTIME, 64'd0, $urandom_range(0, 2));
                1: req(1'b1, A_MTIME, ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15))
                                                                 : {32'($urandom), 32'($urandom)}, $urandom_range(0, 2));
                2: req(1'b1, A_CMP, mt_at(cyc) + 64'($urandom_range(0, 8 * DIV)) - 64'(DIV), $urandom_range(0, 2));
                3: req(1'b0, A_CMP, 64'd0, $urandom_range(0, 2));
                4: req(1'($urandom_range(0, 1)), A_MSIP, {32'($urandom), 32'($urandom)}, $urandom_range(0, 2));
                5: req(1'($urandom_range(0, 1)), unm[$urandom_range(0, 3)], {32'($urandom), 32'($urandom)}, $urandom_range(0, 2));
                default: req(1'b0, A_MSIP, 64'd0, 0);
            endcase
            repeat ($urandom_range(0, 2 * DIV)) @(negedge clk);
        end

        // Reset while a response is pending.
        req(1'b1, A_MSIP, 64'd1, 0);
        req(1'b1, A_CMP, 64'd0, 0);
        @(negedge clk);
        mmio_v = 1'b1; mmio_w = 1'b0; mmio_addr = A_MTIME;
        @(posedge clk);
        #1;
        mmio_v = 1'b0;
        chk("pre_rst_resp_v", 64'(resp_v), 64'(1));
        do_reset();
        repeat (32) @(negedge clk);
        req(1'b0, A_MTIME, 64'd0, 0);
        req(1'b0, A_CMP, 64'd0, 0);
        req(1'b0, A_MSIP, 64'd0, 0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
